parking_gate_arbiter: RTL and testbench
=======================================

PARKING_GATE_ARBITER -- requirements
Module: parking_gate_arbiter

Interface
REQ-001 The block SHALL have parameter OPEN_CYCLES, default 8, meaning the number of cycles the barrier stays open before the car-passage pulse (legal range >= 1).
REQ-002 The block SHALL have parameter PULSE_CYCLES, default 2, meaning the high width in cycles of car_entered and car_exited (legal range >= 1).
REQ-003 The block SHALL have a single clock domain, and reset SHALL be asynchronous and active-high.
REQ-004 clock  in  1  system clock; all state changes on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 entry_req  in  1  entry-lane request, level, held until entry_ack or entry_denied.
REQ-007 entry_is_uni  in  1  entry car class, 1 = university, 0 = free.
REQ-008 exit_req  in  1  exit-lane request, level, held until exit_ack.
REQ-009 exit_is_uni  in  1  exit car class.
REQ-010 uni_is_vacated_space  in  1  1 = a university space is free (from the parking counter).
REQ-011 free_is_vacated_space  in  1  1 = a free space is free (from the parking counter).
REQ-012 gate_open  out  1  barrier open command.
REQ-013 car_entered  out  1  entry-passage pulse; the downstream counter counts on its falling edge.
REQ-014 is_uni_car_entered  out  1  class of the entering car.
REQ-015 car_exited  out  1  exit-passage pulse; the downstream counter counts on its falling edge.
REQ-016 is_uni_car_exited  out  1  class of the exiting car.
REQ-017 entry_ack  out  1  one-cycle pulse when the entry service completes.
REQ-018 exit_ack  out  1  one-cycle pulse when the exit service completes.
REQ-019 entry_denied  out  1  one-cycle pulse when an entry is refused for lack of space.
REQ-020 busy  out  1  1 whenever the FSM is not in IDLE.

Function
REQ-021 The FSM SHALL have five states: IDLE, OPEN, PULSE, CLOSE and SETTLE; there is one barrier, shared by both lanes.
REQ-022 In IDLE with only one request present, that request SHALL be selected.
REQ-023 In IDLE with both requests present, the lane opposite to prio SHALL be selected; prio records the last lane served or denied, and its reset value makes exit win first.
REQ-024 A selected entry whose class has no space (the uni or free vacated flag = 0) SHALL cause the following: entry_denied for one cycle, no gate_open, no car_entered, prio updated, and next state SETTLE.
REQ-025 A selected request with space, or any exit, SHALL latch the lane and class, drive the matching is_uni_car_* output from the next cycle, update prio, and go to OPEN.
REQ-026 OPEN SHALL last exactly OPEN_CYCLES cycles, PULSE exactly PULSE_CYCLES cycles, CLOSE exactly 1 cycle, and SETTLE exactly 1 cycle.
REQ-027 gate_open SHALL be 1 in OPEN, PULSE and CLOSE, and 0 otherwise.
REQ-028 car_entered or car_exited, whichever matches the latched lane, SHALL be 1 only in PULSE.
REQ-029 The matching is_uni_car_* output SHALL remain stable from entry into OPEN through SETTLE; input class changes during service SHALL be ignored.
REQ-030 entry_ack or exit_ack, whichever matches the latched lane, SHALL be 1 only in CLOSE.
REQ-031 SETTLE SHALL ignore all requests, giving requesters one cycle to drop the request; IDLE is re-entered afterwards.
REQ-032 A request that is still high in IDLE after SETTLE SHALL be treated as a new request.
REQ-033 The space flags SHALL be sampled only in IDLE; flag changes during service SHALL not abort it.
REQ-034 The phase timer SHALL be sized for max(OPEN_CYCLES, PULSE_CYCLES), reload on every state entry, and never wrap.
REQ-035 At no time SHALL car_entered and car_exited both be 1, nor entry_ack and exit_ack both be 1.

Reset
REQ-036 While reset is high, all outputs SHALL be 0, state SHALL be IDLE, the timer SHALL be 0, and prio SHALL favour exit, asynchronously.
REQ-037 Reset asserted mid-service SHALL abort the service immediately with no ack; a falling passage pulse caused by reset is acceptable because the counter shares the same reset.

Verification
REQ-038 Reset with all inputs 0 -> all outputs 0 and busy=0 while reset is high and after release.
REQ-039 Uni entry with uni_is_vacated_space=1 -> gate_open high 11 cycles, car_entered high in cycles 9-10 of that window, is_uni_car_entered=1, entry_ack in cycle 11, busy=0 two cycles later.
REQ-040 entry_req and exit_req raised together after reset -> exit fully served first (exit_ack), then entry, with no overlap of gate windows.
REQ-041 Free entry with free_is_vacated_space=0 -> entry_denied for exactly 1 cycle, gate_open=0 and car_entered=0 throughout, IDLE after SETTLE.
REQ-042 Reset pulsed during PULSE -> gate_open, car_exited and busy=0 immediately, no exit_ack, and a fresh request after release is served normally.
REQ-043 entry_is_uni toggled from 1 to 0 during OPEN -> is_uni_car_entered stays 1 through SETTLE.

Source files
------------

// File: rtl/parking_gate_arbiter_if.sv
// Parking gate arbiter bus interface.
// Groups the lane handshakes, space flags and barrier/passage outputs shared between the
// requesting side (master: lane controllers and parking counter) and the arbiter (slave).
//   entry_req / entry_is_uni          entry-lane request and car class
//   exit_req / exit_is_uni            exit-lane request and car class
//   uni_is_vacated_space              a university space is free
//   free_is_vacated_space             a free space is free
//   gate_open                         barrier open command
//   car_entered / is_uni_car_entered  entry-passage pulse and class
//   car_exited / is_uni_car_exited    exit-passage pulse and class
//   entry_ack / exit_ack              one-cycle service-complete pulses
//   entry_denied                      one-cycle entry refusal pulse
//   busy                              arbiter not idle
interface parking_gate_arbiter_if;
   logic entry_req;
   logic entry_is_uni;
   logic exit_req;
   logic exit_is_uni;
   logic uni_is_vacated_space;
   logic free_is_vacated_space;
   logic gate_open;
   logic car_entered;
   logic is_uni_car_entered;
   logic car_exited;
   logic is_uni_car_exited;
   logic entry_ack;
   logic exit_ack;
   logic entry_denied;
   logic busy;

   modport master (
      output entry_req,
      output entry_is_uni,
      output exit_req,
      output exit_is_uni,
      output uni_is_vacated_space,
      output free_is_vacated_space,
      input  gate_open,
      input  car_entered,
      input  is_uni_car_entered,
      input  car_exited,
      input  is_uni_car_exited,
      input  entry_ack,
      input  exit_ack,
      input  entry_denied,
      input  busy
   );

   modport slave (
      input  entry_req,
      input  entry_is_uni,
      input  exit_req,
      input  exit_is_uni,
      input  uni_is_vacated_space,
      input  free_is_vacated_space,
      output gate_open,
      output car_entered,
      output is_uni_car_entered,
      output car_exited,
      output is_uni_car_exited,
      output entry_ack,
      output exit_ack,
      output entry_denied,
      output busy
   );
endinterface

// File: rtl/parking_gate_arbiter.sv
// Parking gate arbiter.
// Shares one barrier between an entry lane and an exit lane. Each service opens the gate for
// OPEN_CYCLES, emits a PULSE_CYCLES passage pulse, closes with a one-cycle ack and then settles
// for one cycle. Entries for a class with no free space are refused without opening the gate.
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-high reset
//   bus    parking_gate_arbiter_if.slave (requests, space flags, gate/passage/ack outputs)
module parking_gate_arbiter #(
   parameter int unsigned OPEN_CYCLES  = 8,
   parameter int unsigned PULSE_CYCLES = 2
) (
   input logic                   clock,
   input logic                   reset,
   parking_gate_arbiter_if.slave bus
);

   localparam int unsigned MaxCycles = (OPEN_CYCLES > PULSE_CYCLES) ? OPEN_CYCLES : PULSE_CYCLES;
   localparam int unsigned TimerW    = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
   localparam logic [TimerW-1:0] OpenLoad  = TimerW'(OPEN_CYCLES - 1);
   localparam logic [TimerW-1:0] PulseLoad = TimerW'(PULSE_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StOpen, StPulse, StClose, StSettle} state_e;

   // Lane encoding for lane_q / prio_q: 0 = entry, 1 = exit.
   state_e             state_q, state_d;
   logic [TimerW-1:0]  timer_q, timer_d;
   logic               lane_q, lane_d;
   logic               uni_q, uni_d;
   logic               served_q, served_d;  // 0 while settling after a denial
   logic               prio_q, prio_d;

   logic               sel_exit;
   logic               has_space;

   // State register
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= StIdle;
         timer_q  <= '0;
         lane_q   <= 1'b0;
         uni_q    <= 1'b0;
         served_q <= 1'b0;
         prio_q   <= 1'b0;  // last served = entry, so exit wins the first tie
      end else begin
         state_q  <= state_d;
         timer_q  <= timer_d;
         lane_q   <= lane_d;
         uni_q    <= uni_d;
         served_q <= served_d;
         prio_q   <= prio_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d   = state_q;
      timer_d   = timer_q;
      lane_d    = lane_q;
      uni_d     = uni_q;
      served_d  = served_q;
      prio_d    = prio_q;
      sel_exit  = bus.exit_req && (!bus.entry_req || !prio_q);
      has_space = bus.entry_is_uni ? bus.uni_is_vacated_space : bus.free_is_vacated_space;

      case (state_q)
         StIdle: begin
            if (bus.entry_req || bus.exit_req) begin
               lane_d = sel_exit;
               prio_d = sel_exit;
               uni_d  = sel_exit ? bus.exit_is_uni : bus.entry_is_uni;
               if (sel_exit || has_space) begin
                  served_d = 1'b1;
                  state_d  = StOpen;
                  timer_d  = OpenLoad;
               end else begin
                  served_d = 1'b0;
                  state_d  = StSettle;
                  timer_d  = '0;
               end
            end
         end
         StOpen: begin
            if (timer_q == '0) begin
               state_d = StPulse;
               timer_d = PulseLoad;
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end
         StPulse: begin
            if (timer_q == '0) begin
               state_d = StClose;
               timer_d = '0;
            end else begin
               timer_d = timer_q - TimerW'(1);
            end
         end
         StClose: begin
            state_d = StSettle;
            timer_d = '0;
         end
         StSettle: begin
            state_d = StIdle;
            timer_d = '0;
         end
         default: begin
            state_d = StIdle;
            timer_d = '0;
         end
      endcase
   end

   logic gate_open_c, car_entered_c, car_exited_c, entry_ack_c, exit_ack_c;
   logic entry_denied_c, busy_c, uni_entered_c, uni_exited_c;

   // Output logic (Moore, so every output is 0 while reset holds the FSM in idle)
   always_comb begin
      gate_open_c    = 1'b0;
      car_entered_c  = 1'b0;
      car_exited_c   = 1'b0;
      entry_ack_c    = 1'b0;
      exit_ack_c     = 1'b0;
      entry_denied_c = 1'b0;
      busy_c         = (state_q != StIdle);
      uni_entered_c  = busy_c && served_q && !lane_q && uni_q;
      uni_exited_c   = busy_c && served_q && lane_q && uni_q;

      case (state_q)
         StOpen: gate_open_c = 1'b1;
         StPulse: begin
            gate_open_c   = 1'b1;
            car_entered_c = !lane_q;
            car_exited_c  = lane_q;
         end
         StClose: begin
            gate_open_c = 1'b1;
            entry_ack_c = !lane_q;
            exit_ack_c  = lane_q;
         end
         StSettle: entry_denied_c = !served_q;
         default: ;
      endcase
   end

   assign bus.gate_open          = gate_open_c;
   assign bus.car_entered        = car_entered_c;
   assign bus.car_exited         = car_exited_c;
   assign bus.is_uni_car_entered = uni_entered_c;
   assign bus.is_uni_car_exited  = uni_exited_c;
   assign bus.entry_ack          = entry_ack_c;
   assign bus.exit_ack           = exit_ack_c;
   assign bus.entry_denied       = entry_denied_c;
   assign bus.busy               = busy_c;

endmodule

// File: tb/tb_parking_gate_arbiter.sv
// Directed bench for parking_gate_arbiter with OPEN_CYCLES=8, PULSE_CYCLES=2.
// Inputs change and outputs are sampled on the falling clock edge. Window cycle k counts
// falling edges after the request was presented: k=1..8 open, 9..10 pulse, 11 close,
// 12 settle, 13 idle.
module tb_parking_gate_arbiter;

   logic clock;
   logic reset;
   int   total;
   int   bad;

   parking_gate_arbiter_if bus ();

   parking_gate_arbiter #(
      .OPEN_CYCLES  (8),
      .PULSE_CYCLES (2)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string tag, input logic obs, input logic exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " gate_open"}, bus.gate_open, 1'b0);
      check({tag, " car_entered"}, bus.car_entered, 1'b0);
      check({tag, " car_exited"}, bus.car_exited, 1'b0);
      check({tag, " is_uni_entered"}, bus.is_uni_car_entered, 1'b0);
      check({tag, " is_uni_exited"}, bus.is_uni_car_exited, 1'b0);
      check({tag, " entry_ack"}, bus.entry_ack, 1'b0);
      check({tag, " exit_ack"}, bus.exit_ack, 1'b0);
      check({tag, " entry_denied"}, bus.entry_denied, 1'b0);
      check({tag, " busy"}, bus.busy, 1'b0);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset = 1'b1;
      bus.entry_req             = 1'b0;
      bus.entry_is_uni          = 1'b0;
      bus.exit_req              = 1'b0;
      bus.exit_is_uni           = 1'b0;
      bus.uni_is_vacated_space  = 1'b0;
      bus.free_is_vacated_space = 1'b0;

      // Reset with all inputs low
      #1;
      check_idle_outputs("rst_held");
      repeat (2) @(negedge clock);
      check_idle_outputs("rst_held2");
      reset = 1'b0;
      repeat (2) @(negedge clock);
      check_idle_outputs("rst_released");

      // Uni entry with uni space available
      bus.entry_req            = 1'b1;
      bus.entry_is_uni         = 1'b1;
      bus.uni_is_vacated_space = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clock);
         check($sformatf("uni_entry k=%0d gate_open", k), bus.gate_open, k <= 11);
         check($sformatf("uni_entry k=%0d car_entered", k), bus.car_entered, k == 9 || k == 10);
         check($sformatf("uni_entry k=%0d car_exited", k), bus.car_exited, 1'b0);
         check($sformatf("uni_entry k=%0d entry_ack", k), bus.entry_ack, k == 11);
         check($sformatf("uni_entry k=%0d exit_ack", k), bus.exit_ack, 1'b0);
         check($sformatf("uni_entry k=%0d is_uni", k), bus.is_uni_car_entered, k <= 12);
         check($sformatf("uni_entry k=%0d busy", k), bus.busy, k <= 12);
         if (k == 11) bus.entry_req = 1'b0;
      end

      // Fresh reset, then both requests together: exit first, then entry
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      bus.entry_req             = 1'b1;
      bus.entry_is_uni          = 1'b0;
      bus.free_is_vacated_space = 1'b1;
      bus.exit_req              = 1'b1;
      bus.exit_is_uni           = 1'b0;
      for (int k = 1; k <= 26; k++) begin
         @(negedge clock);
         check($sformatf("both k=%0d gate_open", k), bus.gate_open,
               (k <= 11) || (k >= 14 && k <= 24));
         check($sformatf("both k=%0d car_exited", k), bus.car_exited, k == 9 || k == 10);
         check($sformatf("both k=%0d exit_ack", k), bus.exit_ack, k == 11);
         check($sformatf("both k=%0d car_entered", k), bus.car_entered, k == 22 || k == 23);
         check($sformatf("both k=%0d entry_ack", k), bus.entry_ack, k == 24);
         check($sformatf("both k=%0d busy", k), bus.busy, (k <= 12) || (k >= 14 && k <= 25));
         if (k == 11) bus.exit_req = 1'b0;
         if (k == 24) bus.entry_req = 1'b0;
      end

      // Free entry with no free space: denied
      bus.entry_req             = 1'b1;
      bus.entry_is_uni          = 1'b0;
      bus.free_is_vacated_space = 1'b0;
      bus.uni_is_vacated_space  = 1'b1;
      for (int k = 1; k <= 3; k++) begin
         @(negedge clock);
         check($sformatf("deny k=%0d entry_denied", k), bus.entry_denied, k == 1);
         check($sformatf("deny k=%0d gate_open", k), bus.gate_open, 1'b0);
         check($sformatf("deny k=%0d car_entered", k), bus.car_entered, 1'b0);
         check($sformatf("deny k=%0d entry_ack", k), bus.entry_ack, 1'b0);
         check($sformatf("deny k=%0d busy", k), bus.busy, k == 1);
         if (k == 1) bus.entry_req = 1'b0;
      end

      // Uni entry with class and space flag changed during OPEN
      bus.entry_req            = 1'b1;
      bus.entry_is_uni         = 1'b1;
      bus.uni_is_vacated_space = 1'b1;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clock);
         check($sformatf("hold k=%0d is_uni", k), bus.is_uni_car_entered, k <= 12);
         check($sformatf("hold k=%0d car_entered", k), bus.car_entered, k == 9 || k == 10);
         check($sformatf("hold k=%0d entry_ack", k), bus.entry_ack, k == 11);
         if (k == 3) begin
            bus.entry_is_uni         = 1'b0;
            bus.uni_is_vacated_space = 1'b0;
         end
         if (k == 11) bus.entry_req = 1'b0;
      end

      // Reset pulsed during the exit PULSE phase
      bus.exit_req    = 1'b1;
      bus.exit_is_uni = 1'b1;
      for (int k = 1; k <= 9; k++) @(negedge clock);
      check("abort pre car_exited", bus.car_exited, 1'b1);
      check("abort pre is_uni_exited", bus.is_uni_car_exited, 1'b1);
      reset = 1'b1;
      #1;
      check("abort gate_open", bus.gate_open, 1'b0);
      check("abort car_exited", bus.car_exited, 1'b0);
      check("abort busy", bus.busy, 1'b0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clock);
         check($sformatf("abort k=%0d exit_ack", k), bus.exit_ack, 1'b0);
         check($sformatf("abort k=%0d gate_open", k), bus.gate_open, 1'b0);
      end
      reset = 1'b0;
      for (int k = 1; k <= 13; k++) begin
         @(negedge clock);
         check($sformatf("after_abort k=%0d gate_open", k), bus.gate_open, k <= 11);
         check($sformatf("after_abort k=%0d car_exited", k), bus.car_exited, k == 9 || k == 10);
         check($sformatf("after_abort k=%0d exit_ack", k), bus.exit_ack, k == 11);
         check($sformatf("after_abort k=%0d is_uni", k), bus.is_uni_car_exited, k <= 12);
         check($sformatf("after_abort k=%0d busy", k), bus.busy, k <= 12);
         if (k == 11) bus.exit_req = 1'b0;
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
